rvfi_eot_monitor: RTL

- Synthesizable, parametrised end-of-test and retirement monitor.
- Observes NR_PORTS RVFI-style commit ports. Detects a tohost write or a cycle timeout, then drains and presents a sticky end-of-test code.
- Counts retired instructions and traps.
- Sits beside the core in the testbench/FPGA top and drives the simulation or board exit logic.

---
 rtl/rvfi_eot_pkg.sv | 25 ++
 rtl/rvfi_eot_monitor_if.sv | 19 +
 rtl/rvfi_eot_prio_sel.sv | 26 ++
 rtl/rvfi_eot_monitor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rvfi_eot_pkg.sv
// rtl/rvfi_eot_pkg.sv - shared types, constants and helpers for the end-of-test monitor
package rvfi_eot_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } eot_state_e;

   localparam logic [31:0] EOT_TIMEOUT_CODE = 32'hFFFF_FFFF;
   localparam int          MAX_PORTS        = 8;

   // Per-port hit vector, sized for the widest supported configuration.
   typedef logic [MAX_PORTS-1:0] hit_vec_t;

   function automatic logic [3:0] popcount(input hit_vec_t v, input int n);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (i < n) c = c + 4'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/rvfi_eot_monitor_if.sv
// rtl/rvfi_eot_monitor_if.sv - RVFI-style commit port bundle between core and monitor
interface rvfi_eot_monitor_if #(
   parameter int NR_PORTS = 2,
   parameter int PLEN     = 56
);
   logic [NR_PORTS-1:0]      valid_i;
   logic [NR_PORTS-1:0]      trap_i;
   logic [NR_PORTS-1:0]      mem_we_i;
   logic [NR_PORTS*PLEN-1:0] mem_paddr_i;
   logic [NR_PORTS*32-1:0]   mem_wdata_i;

   modport master (
      output valid_i, trap_i, mem_we_i, mem_paddr_i, mem_wdata_i
   );

   modport slave (
      input valid_i, trap_i, mem_we_i, mem_paddr_i, mem_wdata_i
   );
endinterface

// File: rtl/rvfi_eot_prio_sel.sv
// rtl/rvfi_eot_prio_sel.sv - lowest-index-first selector over per-port tohost hits
module rvfi_eot_prio_sel #(
   parameter int NR_PORTS = 2,
   parameter int IDX_W    = 1
) (
   input  logic [NR_PORTS-1:0]    hit_i,
   input  logic [NR_PORTS*32-1:0] wdata_i,
   output logic                   hit_o,
   output logic [IDX_W-1:0]       idx_o,
   output logic [31:0]            wdata_o
);

   // Scan from the top down so the lowest hitting port is written last and wins.
   always_comb begin
      hit_o   = |hit_i;
      idx_o   = '0;
      wdata_o = '0;
      for (int i = NR_PORTS - 1; i >= 0; i--) begin
         if (hit_i[i]) begin
            idx_o   = IDX_W'(i);
            wdata_o = wdata_i[i*32 +: 32];
         end
      end
   end

endmodule

// File: rtl/rvfi_eot_monitor.sv
// rtl/rvfi_eot_monitor.sv - tohost/timeout end-of-test detector with retire and trap counters
// Optional trace log is enabled by defining RVFI_EOT_TRACE_EN.
module rvfi_eot_monitor
   import rvfi_eot_pkg::*;
#(
   parameter int NR_PORTS     = 2,
   parameter int PLEN         = 56,
   parameter int CNT_W        = 48,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   rvfi_eot_monitor_if.slave   cmt,
`ifdef RVFI_EOT_TRACE_EN
   input  logic [NR_PORTS*32-1:0] cause_i,
`endif
   input  logic [PLEN-1:0]     tohost_addr_i,
   input  logic [CNT_W-1:0]    timeout_i,
   output logic [31:0]         end_of_test_o,
   output logic                done_o,
   output logic [CNT_W-1:0]    cycle_cnt_o,
   output logic [CNT_W-1:0]    retired_cnt_o,
   output logic [CNT_W-1:0]    trap_cnt_o
);

   localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

   eot_state_e       state_q, state_d;
   logic [31:0]      drain_q, drain_d;
   logic [31:0]      code_q, code_d;
   logic [31:0]      eot_q, eot_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic [CNT_W-1:0] trp_q, trp_d;

   logic [NR_PORTS-1:0] tohost_hit;
   logic                sel_hit;
   logic [IDX_W-1:0]    sel_idx;
   logic [31:0]         sel_wdata;
   logic                timeout_hit;
   logic [3:0]          pop_valid;
   logic [3:0]          pop_trap;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   always_comb begin
      tohost_hit = '0;
      for (int i = 0; i < NR_PORTS; i++) begin
         tohost_hit[i] = cmt.valid_i[i] & cmt.mem_we_i[i] & (tohost_addr_i != '0)
                       & (cmt.mem_paddr_i[i*PLEN +: PLEN] == tohost_addr_i)
                       & cmt.mem_wdata_i[i*32];
      end
   end

   rvfi_eot_prio_sel #(
      .NR_PORTS (NR_PORTS),
      .IDX_W    (IDX_W)
   ) u_prio_sel (
      .hit_i   (tohost_hit),
      .wdata_i (cmt.mem_wdata_i),
      .hit_o   (sel_hit),
      .idx_o   (sel_idx),
      .wdata_o (sel_wdata)
   );

   assign timeout_hit = (timeout_i != '0) && (cyc_q >= timeout_i);
   assign pop_valid   = popcount(hit_vec_t'(cmt.valid_i), NR_PORTS);
   // A trap on a port that also retires is not a separate event.
   assign pop_trap    = popcount(hit_vec_t'(cmt.trap_i & ~cmt.valid_i), NR_PORTS);

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      code_d  = code_q;
      cyc_d   = cyc_q;
      ret_d   = ret_q;
      trp_d   = trp_q;
      if (clear_i) begin
         state_d = RUN;
         drain_d = '0;
         code_d  = '0;
         cyc_d   = '0;
         ret_d   = '0;
         trp_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               cyc_d = sat_add(cyc_q, 4'd1);
               ret_d = sat_add(ret_q, pop_valid);
               trp_d = sat_add(trp_q, pop_trap);
               if (sel_hit || timeout_hit) begin
                  code_d = sel_hit ? sel_wdata : EOT_TIMEOUT_CODE;
                  if (DRAIN_CYCLES == 0) begin
                     state_d = DONE;
                  end else begin
                     state_d = DRAIN;
                     drain_d = 32'(DRAIN_CYCLES);
                  end
               end
            end
            DRAIN: begin
               ret_d   = sat_add(ret_q, pop_valid);
               trp_d   = sat_add(trp_q, pop_trap);
               drain_d = drain_q - 32'd1;
               // Leaving on the last count keeps done at exactly N+1+DRAIN_CYCLES.
               if (drain_q <= 32'd1) state_d = DONE;
            end
            DONE: begin
            end
            default: state_d = RUN;
         endcase
      end
      done_d = (state_d == DONE);
      eot_d  = done_d ? code_d : 32'd0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         drain_q <= '0;
         code_q  <= '0;
         eot_q   <= '0;
         done_q  <= 1'b0;
         cyc_q   <= '0;
         ret_q   <= '0;
         trp_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         code_q  <= code_d;
         eot_q   <= eot_d;
         done_q  <= done_d;
         cyc_q   <= cyc_d;
         ret_q   <= ret_d;
         trp_q   <= trp_d;
      end
   end

   assign end_of_test_o = eot_q;
   assign done_o        = done_q;
   assign cycle_cnt_o   = cyc_q;
   assign retired_cnt_o = ret_q;
   assign trap_cnt_o    = trp_q;

   a_sel_is_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      sel_hit |-> tohost_hit[sel_idx]);

`ifdef RVFI_EOT_TRACE_EN
   always @(posedge clk_i) begin
      if (rst_ni && !clear_i && state_q != DONE) begin
         for (int i = 0; i < NR_PORTS; i++) begin
            if (cmt.valid_i[i])
               $display("%0d %0d %0d", cyc_q, i, ret_q);
            if (cmt.trap_i[i] && !cmt.valid_i[i])
               $display("%0d %0d trap %0d", cyc_q, i, cause_i[i*32 +: 32]);
         end
         if (state_d == DONE)
            $display("%0d exit %08h", cyc_q, code_d);
      end
   end
`endif

endmodule
